// File: rtl/mon_transmitter.sv
// rtl/mon_transmitter.sv - monitor-link serial transmitter: start bit, MSB-first payload, idle-low gap
// Define MON_TX_PARITY_EN to append an even-parity bit after the payload.
module mon_transmitter #(
   parameter int WIDTH      = 40,
   parameter int BIT_CYCLES = 1,
   parameter int GAP_CYCLES = 4
) (
   input  logic             mon_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             from_mon,
   output logic             busy
);
   localparam int HW = $clog2(BIT_CYCLES + 1);
   localparam int BW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

`ifdef MON_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, GAP} state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [HW-1:0]    hold_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             hold_done;
`ifdef MON_TX_PARITY_EN
   logic             parity;
`endif

   assign hold_done = (hold_cnt == HOLD_LAST);

   // from_mon is loaded together with the state change, so it always shows the bit of the current state
   always_ff @(posedge mon_clk) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         hold_cnt <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         from_mon <= 1'b0;
         busy     <= 1'b0;
         in_ready <= 1'b1;
`ifdef MON_TX_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= START;
                  shreg    <= in_data;
                  hold_cnt <= '0;
                  from_mon <= 1'b1;
                  busy     <= 1'b1;
                  in_ready <= 1'b0;
`ifdef MON_TX_PARITY_EN
                  parity   <= ^in_data;
`endif
               end
            end
            START: begin
               if (hold_done) begin
                  state    <= DATA;
                  hold_cnt <= '0;
                  bit_cnt  <= '0;
                  from_mon <= shreg[WIDTH-1];
                  shreg    <= shreg << 1;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            DATA: begin
               if (hold_done) begin
                  hold_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
`ifdef MON_TX_PARITY_EN
                     state    <= PAR;
                     from_mon <= parity;
`else
                     state    <= GAP;
                     gap_cnt  <= '0;
                     from_mon <= 1'b0;
`endif
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     from_mon <= shreg[WIDTH-1];
                     shreg    <= shreg << 1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
`ifdef MON_TX_PARITY_EN
            PAR: begin
               if (hold_done) begin
                  state    <= GAP;
                  hold_cnt <= '0;
                  gap_cnt  <= '0;
                  from_mon <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
`endif
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               from_mon <= 1'b0;
               busy     <= 1'b0;
               in_ready <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mon_transmitter.sv
// tb/tb_mon_transmitter.sv - self-checking bench for mon_transmitter, BIT_CYCLES=1 and BIT_CYCLES=3 instances
module tb_mon_transmitter;
   localparam int W   = 40;
   localparam int GAP = 4;
`ifdef MON_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         mon_clk  = 1'b0;
   logic         reset    = 1'b1;
   logic [W-1:0] in_data  = '0;
   logic         in_valid = 1'b0;
   int checks   = 0;
   int failures = 0;

   always #5 mon_clk = ~mon_clk;

   // Each instance carries a line model: on accept, the whole expected waveform is queued bit-cycle by bit-cycle
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int BC = (g == 0) ? 1 : 3;
      logic from_mon, busy, in_ready;
      bit   q[$];
      bit   active  = 1'b0;
      bit   m_from  = 1'b0;
      bit   m_valid = 1'b0;

      mon_transmitter #(.WIDTH(W), .BIT_CYCLES(BC), .GAP_CYCLES(GAP)) dut (
         .mon_clk (mon_clk),
         .reset   (reset),
         .in_data (in_data),
         .in_valid(in_valid),
         .in_ready(in_ready),
         .from_mon(from_mon),
         .busy    (busy)
      );

      initial forever begin
         @(posedge mon_clk);
         if (reset) begin
            q.delete();
            active  = 1'b0;
            m_from  = 1'b0;
            m_valid = 1'b1;
         end else if (m_valid) begin
            if (!active && in_valid) begin
               for (int i = 0; i < BC; i++) q.push_back(1'b1);
               for (int b = W - 1; b >= 0; b--)
                  for (int i = 0; i < BC; i++) q.push_back(in_data[b]);
`ifdef MON_TX_PARITY_EN
               for (int i = 0; i < BC; i++) q.push_back(^in_data);
`endif
               for (int i = 0; i < GAP; i++) q.push_back(1'b0);
               active = 1'b1;
            end
            if (active) begin
               if (q.size() > 0) m_from = q.pop_front();
               else begin
                  active = 1'b0;
                  m_from = 1'b0;
               end
            end
         end
      end
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge mon_clk);
      if (u[0].m_valid) begin
         check_bit("model0.from_mon", u[0].from_mon, u[0].m_from);
         check_bit("model0.busy",     u[0].busy,     u[0].active);
         check_bit("model0.in_ready", u[0].in_ready, !u[0].active);
      end
      if (u[1].m_valid) begin
         check_bit("model1.from_mon", u[1].from_mon, u[1].m_from);
         check_bit("model1.busy",     u[1].busy,     u[1].active);
         check_bit("model1.in_ready", u[1].in_ready, !u[1].active);
      end
   end

   task automatic tick();
      @(negedge mon_clk);
   endtask

   task automatic wait_idle0();
      int n = 0;
      while (u[0].active && n < 400) begin tick(); n++; end
      check_bit("idle0.in_ready", u[0].in_ready, 1'b1);
   endtask

   task automatic wait_idle1();
      int n = 0;
      while (u[1].active && n < 400) begin tick(); n++; end
      check_bit("idle1.in_ready", u[1].in_ready, 1'b1);
   endtask

   // Sends one word on the BIT_CYCLES=1 instance and checks the line against literal expectations
   task automatic send0(input logic [W-1:0] w, input logic par, input string tag);
      logic [W-1:0] got;
      int ones;
      wait_idle0();
      in_data  = w;
      in_valid = 1'b1;
      @(posedge mon_clk);
      tick();
      in_valid = 1'b0;
      in_data  = ~w;
      check_bit({tag, ".start"}, u[0].from_mon, 1'b1);
      check_bit({tag, ".ready_low"}, u[0].in_ready, 1'b0);
      for (int i = 0; i < W; i++) begin
         tick();
         got[W-1-i] = u[0].from_mon;
      end
      check_vec({tag, ".payload"}, got, w);
`ifdef MON_TX_PARITY_EN
      tick();
      check_bit({tag, ".parity"}, u[0].from_mon, par);
`else
      if (par === 1'bx) $display("note: parity argument unknown");
`endif
      ones = 0;
      for (int i = 0; i < GAP; i++) begin
         tick();
         ones += int'(u[0].from_mon);
      end
      check_int({tag, ".gap_ones"}, ones, 0);
      check_bit({tag, ".busy_in_gap"}, u[0].busy, 1'b1);
      tick();
      check_bit({tag, ".ready_back"}, u[0].in_ready, 1'b1);
      check_bit({tag, ".busy_clear"}, u[0].busy, 1'b0);
   endtask

   initial begin
      logic [W-1:0] got;
      bit           s[127];
      int           ones;

      // Reset held three cycles, with in_valid high throughout: nothing may be accepted
      in_data  = 40'h1122334455;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_bit("rst.from_mon", u[0].from_mon, 1'b0);
         check_bit("rst.busy",     u[0].busy,     1'b0);
         check_bit("rst.in_ready", u[0].in_ready, 1'b1);
      end
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      check_bit("rst_vs_valid.from_mon", u[0].from_mon, 1'b0);
      check_bit("rst_vs_valid.in_ready", u[0].in_ready, 1'b1);

      send0(40'hA50F3C81FF, 1'b0, "single");

      // Back-to-back: valid held high, second word must start right after the first IDLE cycle
      wait_idle0();
      in_data  = 40'h0123456789;
      in_valid = 1'b1;
      @(posedge mon_clk);
      tick();
      in_data = 40'hFEDCBA9876;
      check_bit("b2b.start1", u[0].from_mon, 1'b1);
      for (int i = 0; i < W; i++) begin
         tick();
         got[W-1-i] = u[0].from_mon;
      end
      check_vec("b2b.payload1", got, 40'h0123456789);
      ones = 0;
      for (int i = 0; i < GAP + PB; i++) begin
         tick();
         ones += int'(u[0].from_mon);
      end
      check_int("b2b.gap_ones", ones, PB * 1);
      tick();
      check_bit("b2b.idle_ready", u[0].in_ready, 1'b1);
      check_bit("b2b.idle_line",  u[0].from_mon, 1'b0);
      tick();
      in_valid = 1'b0;
      check_bit("b2b.start2", u[0].from_mon, 1'b1);
      check_bit("b2b.ready2_low", u[0].in_ready, 1'b0);
      for (int i = 0; i < W; i++) begin
         tick();
         got[W-1-i] = u[0].from_mon;
      end
      check_vec("b2b.payload2", got, 40'hFEDCBA9876);

      // BIT_CYCLES=3 instance with a single set LSB
      wait_idle0();
      wait_idle1();
      in_data  = 40'h1;
      in_valid = 1'b1;
      @(posedge mon_clk);
      tick();
      in_valid = 1'b0;
      s[0] = u[1].from_mon;
      for (int i = 1; i < 127; i++) begin
         tick();
         s[i] = u[1].from_mon;
      end
      ones = 0;
      for (int i = 0; i < 3; i++) ones += int'(s[i]);
      check_int("bc3.start_ones", ones, 3);
      ones = 0;
      for (int i = 3; i < 120; i++) ones += int'(s[i]);
      check_int("bc3.zero_bits_ones", ones, 0);
      ones = 0;
      for (int i = 120; i < 123; i++) ones += int'(s[i]);
      check_int("bc3.last_bit_ones", ones, 3);
`ifndef MON_TX_PARITY_EN
      ones = 0;
      for (int i = 123; i < 127; i++) ones += int'(s[i]);
      check_int("bc3.gap_ones", ones, 0);
      tick();
      check_bit("bc3.ready_back", u[1].in_ready, 1'b1);
`endif

      // Reset after bit 20 has been sent
      wait_idle0();
      in_data  = 40'hC3C3C3C3C3;
      in_valid = 1'b1;
      @(posedge mon_clk);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_bit("midrst.from_mon", u[0].from_mon, 1'b0);
      check_bit("midrst.in_ready", u[0].in_ready, 1'b1);
      check_bit("midrst.busy",     u[0].busy,     1'b0);
      send0(40'h8000000001, 1'b0, "after_rst");

`ifdef MON_TX_PARITY_EN
      send0(40'h7, 1'b1, "par7");
      send0(40'h3, 1'b0, "par3");
`endif

      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
